// File: rtl/integration_scheduler.sv
// Correlator integration timebase: sequences an external COUNTER, turns each overflow
// into a frame boundary, and hands one dump request per frame to the readout.
module integration_scheduler #(
  parameter int RESOLUTION = 64,
  parameter int FRAME_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [RESOLUTION-1:0] cfg_period,
  input  logic [RESOLUTION-1:0] cfg_increment,
  input  logic [FRAME_W-1:0]    cfg_frames,
  output logic                  cfg_err,
  input  logic                  start,
  input  logic                  abort,
  output logic [RESOLUTION-1:0] counter_max,
  output logic [RESOLUTION-1:0] increment,
  output logic                  counter_reset,
  input  logic [RESOLUTION-1:0] counter_value,
  input  logic                  counter_overflow,
  output logic                  integrating,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [FRAME_W-1:0]    dump_frame,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic                  stall
);
  typedef enum logic [2:0] {IDLE, CLEAR, ARM, RUN, RESTART, DRAIN} state_t;

  typedef struct packed {
    logic [RESOLUTION-1:0] period;
    logic [RESOLUTION-1:0] incr;
    logic [FRAME_W-1:0]    frames;
  } cfg_t;

  state_t             state_q, state_d;
  cfg_t               cfg_q;
  logic               cfg_ok;
  logic [FRAME_W-1:0] frame_cnt, frame_nxt;
  logic               abort_evt, ovf_evt, stall_evt, last_frame, cfg_bad;

  assign frame_nxt   = frame_cnt + FRAME_W'(1);
  assign abort_evt   = abort && (state_q != IDLE);
  assign ovf_evt     = (state_q == RUN) && counter_overflow && !abort_evt;
  // Counter passed max without ever flagging overflow: step never lands on max.
  assign stall_evt   = (state_q == RUN) && !counter_overflow &&
                       (counter_value >= cfg_q.period) && !abort_evt;
  assign last_frame  = (cfg_q.frames != '0) && (frame_nxt == cfg_q.frames);
  assign cfg_bad     = (cfg_period == '0) || (cfg_increment == '0);

  assign cfg_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign counter_max = cfg_q.period;
  assign increment   = cfg_q.incr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    counter_reset = 1'b1;
    integrating   = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE:    if (start && cfg_ok) state_d = CLEAR;
      CLEAR:   state_d = ARM;
      ARM: begin
        counter_reset = 1'b0;
        if (counter_value == '0) state_d = RUN;
      end
      RUN: begin
        counter_reset = 1'b0;
        integrating   = !counter_overflow;
        if (counter_overflow)                     state_d = last_frame ? DRAIN : RESTART;
        else if (counter_value >= cfg_q.period)   state_d = IDLE;
      end
      RESTART: state_d = ARM;
      DRAIN: begin
        if (!dump_valid) begin
          state_d = IDLE;
          done    = !abort;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_evt) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q      <= '0;
      cfg_ok     <= 1'b0;
      cfg_err    <= 1'b0;
      frame_cnt  <= '0;
      dump_valid <= 1'b0;
      dump_frame <= '0;
      overrun    <= 1'b0;
      stall      <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (state_q == IDLE) begin
        if (cfg_valid) begin
          if (cfg_bad) cfg_err <= 1'b1;
          else begin
            cfg_q   <= '{period: cfg_period, incr: cfg_increment, frames: cfg_frames};
            cfg_ok  <= 1'b1;
            overrun <= 1'b0;
            stall   <= 1'b0;
          end
        end
        if (start && !cfg_ok) cfg_err <= 1'b1;
      end
      if (state_q == CLEAR) frame_cnt <= '0;
      if (ovf_evt)          frame_cnt <= frame_nxt;
      if (stall_evt)        stall     <= 1'b1;
      // An accept in the same cycle as a new frame frees the slot, so no overrun.
      if (abort_evt) dump_valid <= 1'b0;
      else if (ovf_evt) begin
        if (dump_valid && !dump_ready) overrun <= 1'b1;
        else begin
          dump_valid <= 1'b1;
          dump_frame <= frame_cnt;
        end
      end else if (dump_valid && dump_ready) dump_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_integration_scheduler.sv
// Bench for integration_scheduler: COUNTER model plus a frame-timeline / dump-slot
// reference model, directed cases and randomized runs.
module tb_integration_scheduler;
  localparam int RES = 64;
  localparam int FW  = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [RES-1:0] cfg_period = '0;
  logic [RES-1:0] cfg_increment = '0;
  logic [FW-1:0]  cfg_frames = '0;
  logic           cfg_err;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [RES-1:0] counter_max, increment;
  logic           counter_reset;
  logic [RES-1:0] counter_value;
  logic           counter_overflow;
  logic           integrating, dump_valid;
  logic           dump_ready = 1'b0;
  logic [FW-1:0]  dump_frame;
  logic           busy, done, overrun, stall;

  int total = 0;
  int bad   = 0;
  bit m_ovr = 1'b0;

  logic [RES-1:0] cval;
  logic           run_q;

  always #5 clk = ~clk;

  integration_scheduler #(.RESOLUTION(RES), .FRAME_W(FW)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_period(cfg_period),
    .cfg_increment(cfg_increment), .cfg_frames(cfg_frames), .cfg_err(cfg_err),
    .start(start), .abort(abort),
    .counter_max(counter_max), .increment(increment), .counter_reset(counter_reset),
    .counter_value(counter_value), .counter_overflow(counter_overflow),
    .integrating(integrating), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_frame(dump_frame), .busy(busy), .done(done), .overrun(overrun), .stall(stall)
  );

  // COUNTER: starts stepping one cycle after its reset drops; overflow on exact hit of max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cval  <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= !counter_reset;
      if (counter_reset) cval <= '0;
      else if (run_q)    cval <= cval + increment;
    end
  end
  assign counter_value    = cval;
  assign counter_overflow = run_q && (cval == counter_max);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  task automatic send_cfg(input int p, input int inc, input int f);
    cfg_valid     = 1'b1;
    cfg_period    = 64'(p);
    cfg_increment = 64'(inc);
    cfg_frames    = FW'(f);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Frame k occupies cycles rel=k*len .. k*len+len-1 after start (rel 0 = ARM):
  // ARM, n integrating RUN cycles, overflow cycle, RESTART/DRAIN.
  task automatic run(input int p, input int inc, input int f, input bit do_cfg,
                     input int rmode, input int abort_at);
    int n, len, rel, k, r;
    bit pend, live, drain, ab, acc, ended;
    logic [FW-1:0] pidx;
    n = p / inc; len = n + 3; pend = 1'b0; pidx = '0; ended = 1'b0;
    if (do_cfg) begin
      send_cfg(p, inc, f);
      m_ovr = 1'b0;
      chk("cfg_err_ok", 64'(cfg_err), 64'(0));
      chk("cfg_max", counter_max, 64'(p));
      chk("cfg_inc", increment, 64'(inc));
      chk("ovr_clr", 64'(overrun), 64'(0));
      chk("stall_clr", 64'(stall), 64'(0));
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t < 400 && !ended; t++) begin
      rel   = t - 2;
      k     = (rel < 0) ? 0 : rel / len;
      r     = (rel < 0) ? -1 : rel % len;
      live  = (rel >= 0) && (f == 0 || k < f) && (r <= n + 1);
      drain = (f != 0) && (rel >= (f - 1) * len + n + 2);
      chk("busy", 64'(busy), 64'(1));
      chk("integrating", 64'(integrating), 64'(live && r >= 1 && r <= n));
      chk("counter_reset", 64'(counter_reset), 64'(!live));
      chk("dump_valid", 64'(dump_valid), 64'(pend));
      if (pend) chk("dump_frame", 64'(dump_frame), 64'(pidx));
      chk("overrun", 64'(overrun), 64'(m_ovr));
      chk("done", 64'(done), 64'(drain && !pend));
      chk("max_hold", counter_max, 64'(p));
      if (drain && !pend) begin
        cfg_valid  = 1'b0;
        dump_ready = 1'b0;
        @(negedge clk);
        chk("post_busy", 64'(busy), 64'(0));
        chk("post_done", 64'(done), 64'(0));
        chk("post_cfg_ready", 64'(cfg_ready), 64'(1));
        chk("post_creset", 64'(counter_reset), 64'(1));
        ended = 1'b1;
      end else begin
        ab    = (t == abort_at);
        abort = ab;
        case (rmode)
          0:       dump_ready = ($urandom_range(0, 1) == 1);
          1:       dump_ready = 1'b1;
          2:       dump_ready = (t > 18);
          default: dump_ready = 1'b0;
        endcase
        cfg_valid     = ($urandom_range(0, 1) == 1);
        cfg_period    = 64'($urandom_range(0, 7));
        cfg_increment = 64'($urandom_range(0, 3));
        cfg_frames    = FW'($urandom_range(0, 15));
        acc = pend && dump_ready;
        if (ab) pend = 1'b0;
        else if (live && r == n + 1) begin
          if (pend && !acc) m_ovr = 1'b1;
          else begin
            pend = 1'b1;
            pidx = FW'(k);
          end
        end else if (acc) pend = 1'b0;
        @(negedge clk);
        if (ab) begin
          abort     = 1'b0;
          cfg_valid = 1'b0;
          chk("abort_busy", 64'(busy), 64'(0));
          chk("abort_dump", 64'(dump_valid), 64'(0));
          chk("abort_creset", 64'(counter_reset), 64'(1));
          chk("abort_done", 64'(done), 64'(0));
          ended = 1'b1;
        end
      end
    end
    cfg_valid  = 1'b0;
    dump_ready = 1'b0;
    chk("run_finished", 64'(ended), 64'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ic, steps, inc, n, f, ab;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'(1));
    chk("rst_creset", 64'(counter_reset), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_dump", 64'(dump_valid), 64'(0));
    chk("rst_max", counter_max, 64'(0));
    chk("rst_inc", increment, 64'(0));
    chk("rst_flags", 64'({cfg_err, integrating, done, overrun, stall}), 64'(0));

    // Rejected configs and start without a valid config.
    send_cfg(0, 1, 1);
    chk("err_period0", 64'(cfg_err), 64'(1));
    @(negedge clk);
    chk("err_pulse_end", 64'(cfg_err), 64'(0));
    send_cfg(5, 0, 1);
    chk("err_incr0", 64'(cfg_err), 64'(1));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_start", 64'(cfg_err), 64'(1));
    chk("err_busy", 64'(busy), 64'(0));
    chk("err_max_kept", counter_max, 64'(0));

    // Three frames, readout always ready.
    run(10, 1, 3, 1'b1, 1, 0);

    // Step never lands on max: stall.
    send_cfg(10, 3, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ic = 0; steps = 1;
    while (busy && steps < 60) begin
      ic += int'(integrating);
      @(negedge clk);
      steps++;
    end
    chk("stall_steps", 64'(steps), 64'(8));
    chk("stall_int", 64'(ic), 64'(5));
    chk("stall_flag", 64'(stall), 64'(1));
    chk("stall_nodump", 64'(dump_valid), 64'(0));
    chk("stall_creset", 64'(counter_reset), 64'(1));
    run(4, 1, 1, 1'b1, 1, 0);

    // Readout stalled: overrun, then recovery; continuous mode ended by abort.
    run(4, 1, 0, 1'b1, 2, 45);

    // Abort mid-RUN with a dump pending, then restart without reconfiguring.
    run(4, 1, 2, 1'b1, 3, 11);
    run(4, 1, 2, 1'b0, 1, 0);

    // Frame index wraps in continuous mode.
    run(1, 1, 0, 1'b1, 1, 74);

    for (int i = 0; i < 10; i++) begin
      inc = int'($urandom_range(1, 4));
      n   = int'($urandom_range(1, 6));
      f   = int'($urandom_range(1, 4));
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      run(inc * n, inc, f, 1'b1, 0, ab);
    end

    // Asynchronous reset mid-run.
    send_cfg(10, 1, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_reset_int", 64'(integrating), 64'(1));
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_cfg_ready", 64'(cfg_ready), 64'(1));
    chk("arst_creset", 64'(counter_reset), 64'(1));
    chk("arst_max", counter_max, 64'(0));
    chk("arst_inc", increment, 64'(0));
    chk("arst_flags", 64'({cfg_err, integrating, dump_valid, done, overrun, stall}), 64'(0));
    m_ovr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("arst_start_err", 64'(cfg_err), 64'(1));
    chk("arst_start_idle", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
